counter_hs_sched: RTL and testbench

COUNTER_HS_SCHED -- requirements
Module: counter_hs_sched

---
 rtl/counter_hs_sched.sv | 167 ++++++++++++++++
 tb/tb_counter_hs_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_hs_sched.sv
// Two-requester round-robin driver for a 4-phase counter input, plus an output-side auto-acknowledge and stall watchdog.
// Latency: grant 1 cycle after req, each ai/ro edge seen SYNC_DEPTH cycles late; no back-to-back grants, req holds until done.
module counter_hs_sched #(
    parameter int SYNC_DEPTH = 2,
    parameter int TIMEOUT    = 1023,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    output logic [1:0]       done,
    output logic             ri,
    input  logic             ai,
    input  logic             ro,
    output logic             ao,
    output logic [CNT_W-1:0] in_cnt,
    output logic [CNT_W-1:0] out_cnt,
    output logic             err,
    input  logic             clr_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RISE = 3'd1,
        FALL = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t                state_q, state_d;
    logic [SYNC_DEPTH-1:0] ai_sync_q, ai_sync_d;
    logic [SYNC_DEPTH-1:0] ro_sync_q, ro_sync_d;
    logic                  ri_q, ri_d;
    logic                  ao_q, ao_d;
    logic [1:0]            done_q, done_d;
    logic                  err_q, err_d;
    logic [15:0]           wait_q, wait_d;
    logic                  grant_q, grant_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;

    logic        ai_s;
    logic        ro_s;
    logic        pick;
    logic [15:0] wait_inc;

    assign ai_s = ai_sync_q[SYNC_DEPTH-1];
    assign ro_s = ro_sync_q[SYNC_DEPTH-1];

    always_comb begin
        ai_sync_d = {ai_sync_q[SYNC_DEPTH-2:0], ai};
        ro_sync_d = {ro_sync_q[SYNC_DEPTH-2:0], ro};

        // Contention goes to whoever was not served last; a lone request wins outright.
        if (req == 2'b11) begin
            pick = ~last_q;
        end else begin
            pick = req[1];
        end

        wait_inc  = wait_q + 16'd1;
        state_d   = state_q;
        ri_d      = ri_q;
        done_d    = 2'b00;
        err_d     = err_q;
        wait_d    = wait_q;
        grant_d   = grant_q;
        last_d    = last_q;
        in_cnt_d  = in_cnt_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d = pick;
                    last_d  = pick;
                    ri_d    = 1'b1;
                    wait_d  = 16'd0;
                    state_d = RISE;
                end
            end
            RISE: begin
                if (ai_s) begin
                    ri_d    = 1'b0;
                    wait_d  = 16'd0;
                    state_d = FALL;
                end else if (wait_inc == TIMEOUT_W) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    wait_d  = wait_inc;
                end
            end
            FALL: begin
                if (!ai_s) begin
                    done_d   = grant_q ? 2'b10 : 2'b01;
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    state_d  = DONE;
                end else if (wait_inc == TIMEOUT_W) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    wait_d  = wait_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                // ri stays frozen until software intervenes; recovery is silent.
                if (clr_err) begin
                    err_d   = 1'b0;
                    ri_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ri_d    = 1'b0;
            end
        endcase

        // ao_q holds the previous ro_s, so ao_q & ~ro_s marks the falling edge.
        ao_d      = ro_s;
        out_cnt_d = out_cnt_q + CNT_W'(ao_q & ~ro_s);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ai_sync_q <= '0;
            ro_sync_q <= '0;
            ri_q      <= 1'b0;
            ao_q      <= 1'b0;
            done_q    <= 2'b00;
            err_q     <= 1'b0;
            wait_q    <= 16'd0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ai_sync_q <= ai_sync_d;
            ro_sync_q <= ro_sync_d;
            ri_q      <= ri_d;
            ao_q      <= ao_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign ri      = ri_q;
    assign ao      = ao_q;
    assign done    = done_q;
    assign err     = err_q;
    assign in_cnt  = in_cnt_q;
    assign out_cnt = out_cnt_q;

endmodule

// File: tb/tb_counter_hs_sched.sv
// Bench for counter_hs_sched: directed scenarios plus a per-cycle model of the output delay line and counters.
module tb_counter_hs_sched;
    localparam int SD = 2;
    localparam int TO = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [1:0]    done;
    logic          ri;
    logic          ai = 1'b0;
    logic          ro = 1'b0;
    logic          ao;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          err;
    logic          clr_err = 1'b0;

    counter_hs_sched #(.SYNC_DEPTH(SD), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .ri(ri), .ai(ai),
        .ro(ro), .ao(ao), .in_cnt(in_cnt), .out_cnt(out_cnt), .err(err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit stall = 1'b0;
    bit allow_err = 1'b0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Counter-input environment: ai echoes ri three cycles later unless stalled.
    initial begin
        logic [2:0] rh;
        rh = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            rh = {rh[1:0], ri};
            ai = stall ? 1'b0 : rh[2];
        end
    end

    // Model: ao is ro as sampled SD edges earlier; out_cnt counts ao falls; in_cnt counts done pulses.
    logic [7:0] h = 8'h00;
    logic       pa;
    int         oc = 0;
    int         dc = 0;
    logic [1:0] prev_done = 2'b00;

    always @(posedge clk) begin
        if (!rst_n) begin
            h = 8'h00;
            oc = 0;
            dc = 0;
            started = 1'b1;
        end else begin
            pa = h[SD];
            h = {h[6:0], ro};
            if (pa && !h[SD]) oc++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (done != 2'b00) dc++;
            chk("ao_delay", ao, h[SD]);
            chk("out_cnt_model", out_cnt, oc % 16);
            chk("in_cnt_model", in_cnt, dc % 16);
            chk("done_onehot", $onehot0(done), 1);
            chk("done_spacing", (done != 2'b00) && (prev_done != 2'b00), 0);
            if (!allow_err) chk("err_quiet", err, 0);
            prev_done = done;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output logic [1:0] d);
        d = 2'b00;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                d = done;
                break;
            end
        end
        tests++;
        if (d == 2'b00) begin
            fails++;
            $display("FAIL wait_done: no done pulse within 80 cycles at %0t", $time);
        end
    endtask

    task automatic wait_ri(output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ri) begin
                c = 0;
                break;
            end
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b00;
        ro = 1'b0;
        step(3);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] d;
        logic [1:0] order [4];
        int cnt;
        int dc0;

        // Reset values
        step(3);
        chk("rst_ri", ri, 0);
        chk("rst_ao", ao, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_cnt", in_cnt, 0);
        chk("rst_out_cnt", out_cnt, 0);
        rst_n = 1'b1;
        step(2);

        // Single request from requester 0
        req = 2'b01;
        step(1);
        chk("single_ri_rise", ri, 1);
        wait_done(d);
        req = 2'b00;
        chk("single_done", d, 2'b01);
        step(1);
        chk("single_done_one_cycle", done, 0);
        step(20);
        chk("single_in_cnt", in_cnt, 1);

        // Contention: grants alternate starting with requester 0
        do_reset;
        step(2);
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_done(d);
            order[i] = d;
        end
        req = 2'b00;
        chk("rr_grant0", order[0], 2'b01);
        chk("rr_grant1", order[1], 2'b10);
        chk("rr_grant2", order[2], 2'b01);
        chk("rr_grant3", order[3], 2'b10);
        step(20);
        chk("rr_in_cnt", in_cnt, 4);

        // Output side: five ro pulses
        for (int i = 0; i < 5; i++) begin
            ro = 1'b1;
            if (i == 0) begin
                step(2);
                chk("ao_not_yet", ao, 0);
                step(1);
                chk("ao_rise", ao, 1);
                step(1);
            end else begin
                step(4);
            end
            ro = 1'b0;
            step(4);
        end
        step(5);
        chk("out_cnt_five", out_cnt, 5);

        // Stall: ai stuck low
        stall = 1'b1;
        allow_err = 1'b1;
        dc0 = dc;
        req = 2'b01;
        wait_ri(cnt);
        req = 2'b00;
        chk("stall_ri_rise", cnt, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cnt++;
            if (err) break;
        end
        chk("stall_err_delay", cnt, 8);
        chk("stall_ri_held", ri, 1);
        step(3);
        chk("stall_err_sticky", err, 1);
        chk("stall_ri_still", ri, 1);
        chk("stall_no_done", dc, dc0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("clr_err_err", err, 0);
        chk("clr_err_ri", ri, 0);
        step(1);
        allow_err = 1'b0;
        step(5);
        stall = 1'b0;
        step(10);
        chk("clr_idle_ri", ri, 0);
        chk("clr_no_done", dc, dc0);

        // Wrap: 17 handshakes on a 4-bit counter
        do_reset;
        step(2);
        for (int i = 0; i < 17; i++) begin
            req = 2'b01;
            wait_done(d);
            req = 2'b00;
            step(2);
        end
        step(15);
        chk("wrap_in_cnt", in_cnt, 1);
        chk("wrap_err", err, 0);

        // Reset while ri is high
        req = 2'b01;
        wait_ri(cnt);
        chk("rst_rise_ri_seen", cnt, 0);
        rst_n = 1'b0;
        req = 2'b00;
        step(1);
        chk("rst_rise_ri", ri, 0);
        chk("rst_rise_in_cnt", in_cnt, 0);
        chk("rst_rise_out_cnt", out_cnt, 0);
        chk("rst_rise_done", done, 0);
        rst_n = 1'b1;
        step(12);
        chk("rst_rise_no_done", dc, 0);
        chk("rst_rise_idle", ri, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
